// File: rtl/ipm2l_hsstlp_lane_rst_fsm_v1_0.sv
// Lane reset sequencer: PLL-done -> lane power-up -> TX reset -> RX reset -> CDR qualify.
// Optional CDR alignment timeout retry enabled by macro IPM2L_HSSTLP_LANE_CDR_TIMEOUT_EN.
module ipm2l_hsstlp_lane_rst_fsm_v1_0 #(
    parameter int FREE_CLOCK_FREQ = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pll_done,
    input  logic i_cdr_align,
    output logic P_LANE_PD,
    output logic P_TX_RST,
    output logic P_RX_RST,
    output logic o_txlane_done,
    output logic o_rxlane_done
);

    localparam logic [15:0] LANE_PD_CNTR_VALUE    = 16'(2 * (10 * FREE_CLOCK_FREQ));
    localparam logic [15:0] TX_RST_CNTR_VALUE     = 16'(2 * (1 * FREE_CLOCK_FREQ));
    localparam logic [15:0] RX_RST_CNTR_VALUE     = 16'(2 * (1 * FREE_CLOCK_FREQ));
    localparam logic [15:0] CDR_STABLE_CNTR_VALUE = 16'(2 * (5 * FREE_CLOCK_FREQ));
`ifdef IPM2L_HSSTLP_LANE_CDR_TIMEOUT_EN
    localparam logic [15:0] CDR_TIMEOUT_CNTR_VALUE = 16'(2 * (50 * FREE_CLOCK_FREQ));
`endif

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LANE_PD  = 3'd1,
        TX_RST   = 3'd2,
        RX_RST   = 3'd3,
        WAIT_CDR = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] cntr;
    logic [15:0] cntr_nxt;
    logic        cdr_meta;
    logic        cdr_sync;
    logic        lane_pd_nxt;
    logic        tx_rst_nxt;
    logic        rx_rst_nxt;
    logic        txlane_done_nxt;
    logic        rxlane_done_nxt;
`ifdef IPM2L_HSSTLP_LANE_CDR_TIMEOUT_EN
    logic [15:0] tmo_cntr;
    logic [15:0] tmo_cntr_nxt;
`endif

    // i_cdr_align comes straight from the analog CDR, so it is double-registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdr_meta <= 1'b0;
            cdr_sync <= 1'b0;
        end else begin
            cdr_meta <= i_cdr_align;
            cdr_sync <= cdr_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cntr          <= 16'd0;
            P_LANE_PD     <= 1'b1;
            P_TX_RST      <= 1'b1;
            P_RX_RST      <= 1'b1;
            o_txlane_done <= 1'b0;
            o_rxlane_done <= 1'b0;
        end else begin
            state         <= state_nxt;
            cntr          <= cntr_nxt;
            P_LANE_PD     <= lane_pd_nxt;
            P_TX_RST      <= tx_rst_nxt;
            P_RX_RST      <= rx_rst_nxt;
            o_txlane_done <= txlane_done_nxt;
            o_rxlane_done <= rxlane_done_nxt;
        end
    end

`ifdef IPM2L_HSSTLP_LANE_CDR_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cntr <= 16'd0;
        end else begin
            tmo_cntr <= tmo_cntr_nxt;
        end
    end

    // Held at zero outside WAIT_CDR, which doubles as the clear on entry
    always_comb begin
        tmo_cntr_nxt = 16'd0;
        if (state == WAIT_CDR && state_nxt == WAIT_CDR) begin
            tmo_cntr_nxt = tmo_cntr + 16'd1;
        end
    end
`endif

    always_comb begin
        state_nxt       = state;
        cntr_nxt        = cntr;
        lane_pd_nxt     = P_LANE_PD;
        tx_rst_nxt      = P_TX_RST;
        rx_rst_nxt      = P_RX_RST;
        txlane_done_nxt = o_txlane_done;
        rxlane_done_nxt = o_rxlane_done;

        // Losing PLL lock overrides every other transition
        if (state != IDLE && !i_pll_done) begin
            state_nxt       = IDLE;
            cntr_nxt        = 16'd0;
            lane_pd_nxt     = 1'b1;
            tx_rst_nxt      = 1'b1;
            rx_rst_nxt      = 1'b1;
            txlane_done_nxt = 1'b0;
            rxlane_done_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cntr_nxt        = 16'd0;
                    lane_pd_nxt     = 1'b1;
                    tx_rst_nxt      = 1'b1;
                    rx_rst_nxt      = 1'b1;
                    txlane_done_nxt = 1'b0;
                    rxlane_done_nxt = 1'b0;
                    if (i_pll_done) begin
                        state_nxt = LANE_PD;
                    end
                end
                LANE_PD: begin
                    if (cntr == LANE_PD_CNTR_VALUE) begin
                        state_nxt   = TX_RST;
                        cntr_nxt    = 16'd0;
                        lane_pd_nxt = 1'b0;
                    end else begin
                        cntr_nxt = cntr + 16'd1;
                    end
                end
                TX_RST: begin
                    if (cntr == TX_RST_CNTR_VALUE) begin
                        state_nxt       = RX_RST;
                        cntr_nxt        = 16'd0;
                        tx_rst_nxt      = 1'b0;
                        txlane_done_nxt = 1'b1;
                    end else begin
                        cntr_nxt = cntr + 16'd1;
                    end
                end
                RX_RST: begin
                    rx_rst_nxt      = 1'b1;
                    rxlane_done_nxt = 1'b0;
                    if (cntr == RX_RST_CNTR_VALUE) begin
                        state_nxt  = WAIT_CDR;
                        cntr_nxt   = 16'd0;
                        rx_rst_nxt = 1'b0;
                    end else begin
                        cntr_nxt = cntr + 16'd1;
                    end
                end
                WAIT_CDR: begin
                    // Only an unbroken run of aligned cycles qualifies the lane
                    if (!cdr_sync) begin
                        cntr_nxt = 16'd0;
                    end else if (cntr == CDR_STABLE_CNTR_VALUE) begin
                        state_nxt       = DONE;
                        cntr_nxt        = 16'd0;
                        rxlane_done_nxt = 1'b1;
                    end else begin
                        cntr_nxt = cntr + 16'd1;
                    end
`ifdef IPM2L_HSSTLP_LANE_CDR_TIMEOUT_EN
                    if (state_nxt == WAIT_CDR && tmo_cntr == CDR_TIMEOUT_CNTR_VALUE) begin
                        state_nxt       = RX_RST;
                        cntr_nxt        = 16'd0;
                        rx_rst_nxt      = 1'b1;
                        rxlane_done_nxt = 1'b0;
                    end
`endif
                end
                DONE: begin
                    if (!cdr_sync) begin
                        state_nxt       = RX_RST;
                        cntr_nxt        = 16'd0;
                        rx_rst_nxt      = 1'b1;
                        rxlane_done_nxt = 1'b0;
                    end
                end
                default: begin
                    state_nxt       = IDLE;
                    cntr_nxt        = 16'd0;
                    lane_pd_nxt     = 1'b1;
                    tx_rst_nxt      = 1'b1;
                    rx_rst_nxt      = 1'b1;
                    txlane_done_nxt = 1'b0;
                    rxlane_done_nxt = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ipm2l_hsstlp_lane_rst_fsm_v1_0.sv
// Directed bench for the lane reset sequencer at FREE_CLOCK_FREQ=100.
module tb_ipm2l_hsstlp_lane_rst_fsm_v1_0;

    logic clk;
    logic rst_n;
    logic i_pll_done;
    logic i_cdr_align;
    logic P_LANE_PD;
    logic P_TX_RST;
    logic P_RX_RST;
    logic o_txlane_done;
    logic o_rxlane_done;

    int total = 0;
    int bad   = 0;

    ipm2l_hsstlp_lane_rst_fsm_v1_0 #(.FREE_CLOCK_FREQ(100)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_pll_done    (i_pll_done),
        .i_cdr_align   (i_cdr_align),
        .P_LANE_PD     (P_LANE_PD),
        .P_TX_RST      (P_TX_RST),
        .P_RX_RST      (P_RX_RST),
        .o_txlane_done (o_txlane_done),
        .o_rxlane_done (o_rxlane_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_output(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_lane_pd"}, P_LANE_PD, 1'b1);
        check_output({tag, "_tx_rst"}, P_TX_RST, 1'b1);
        check_output({tag, "_rx_rst"}, P_RX_RST, 1'b1);
        check_output({tag, "_txdone"}, o_txlane_done, 1'b0);
        check_output({tag, "_rxdone"}, o_rxlane_done, 1'b0);
    endtask

    initial begin
        rst_n       = 1'b1;
        i_pll_done  = 1'b0;
        i_cdr_align = 1'b1;
        #2 rst_n = 1'b0;
        tick(3);
        check_reset_values("reset");

        // IDLE holds without PLL done
        rst_n = 1'b1;
        tick(5);
        check_reset_values("idle_hold");

        // Full bring-up sequence
        i_pll_done = 1'b1;
        tick(2001);
        check_output("lane_pd_before", P_LANE_PD, 1'b1);
        tick(1);
        check_output("lane_pd_fall", P_LANE_PD, 1'b0);
        check_output("tx_rst_held", P_TX_RST, 1'b1);
        tick(200);
        check_output("tx_rst_before", P_TX_RST, 1'b1);
        check_output("txdone_before", o_txlane_done, 1'b0);
        tick(1);
        check_output("tx_rst_fall", P_TX_RST, 1'b0);
        check_output("txdone_rise", o_txlane_done, 1'b1);
        check_output("rx_rst_held", P_RX_RST, 1'b1);
        tick(200);
        check_output("rx_rst_before", P_RX_RST, 1'b1);
        tick(1);
        check_output("rx_rst_fall", P_RX_RST, 1'b0);
        check_output("rxdone_wait", o_rxlane_done, 1'b0);
        tick(1000);
        check_output("rxdone_before", o_rxlane_done, 1'b0);
        tick(1);
        check_output("rxdone_rise", o_rxlane_done, 1'b1);

        // Alignment loss in DONE re-runs the RX reset
        i_cdr_align = 1'b0;
        tick(2);
        check_output("cdr_loss_rxdone_lat", o_rxlane_done, 1'b1);
        tick(1);
        check_output("cdr_loss_rx_rst", P_RX_RST, 1'b1);
        check_output("cdr_loss_rxdone", o_rxlane_done, 1'b0);
        check_output("cdr_loss_txdone", o_txlane_done, 1'b1);
        i_cdr_align = 1'b1;
        tick(200);
        check_output("realign_rx_rst_before", P_RX_RST, 1'b1);
        tick(1);
        check_output("realign_rx_rst_fall", P_RX_RST, 1'b0);
        tick(1000);
        check_output("realign_rxdone_before", o_rxlane_done, 1'b0);
        tick(1);
        check_output("realign_rxdone_rise", o_rxlane_done, 1'b1);

        // A 3-cycle glitch at stable count 500 restarts qualification
        i_cdr_align = 1'b0;
        tick(3);
        i_cdr_align = 1'b1;
        tick(201);
        check_output("glitch_rx_rst_fall", P_RX_RST, 1'b0);
        tick(500);
        i_cdr_align = 1'b0;
        tick(3);
        i_cdr_align = 1'b1;
        tick(1002);
        check_output("glitch_rxdone_before", o_rxlane_done, 1'b0);
        tick(1);
        check_output("glitch_rxdone_rise", o_rxlane_done, 1'b1);

        // PLL loss in DONE
        i_pll_done = 1'b0;
        tick(1);
        check_reset_values("pll_loss_done");
        i_pll_done = 1'b1;
        tick(2001);
        check_output("restart1_lane_pd_before", P_LANE_PD, 1'b1);
        tick(1);
        check_output("restart1_lane_pd_fall", P_LANE_PD, 1'b0);

        // PLL loss in TX_RST
        tick(100);
        i_pll_done = 1'b0;
        tick(1);
        check_reset_values("pll_loss_tx");
        i_pll_done = 1'b1;
        tick(2001);
        check_output("restart2_lane_pd_before", P_LANE_PD, 1'b1);
        tick(1);
        check_output("restart2_lane_pd_fall", P_LANE_PD, 1'b0);
        tick(200);
        check_output("restart2_tx_rst_before", P_TX_RST, 1'b1);
        tick(1);
        check_output("restart2_tx_rst_fall", P_TX_RST, 1'b0);

        // Asynchronous reset in the middle of RX_RST
        tick(100);
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");

        // Permanent misalignment
        i_cdr_align = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(2404);
        check_output("noalign_rx_rst_fall", P_RX_RST, 1'b0);
        check_output("noalign_txdone", o_txlane_done, 1'b1);
`ifdef IPM2L_HSSTLP_LANE_CDR_TIMEOUT_EN
        tick(10000);
        check_output("timeout_rx_rst_before", P_RX_RST, 1'b0);
        tick(1);
        check_output("timeout_rx_rst_rise", P_RX_RST, 1'b1);
        tick(200);
        check_output("timeout_rx_rst_hold", P_RX_RST, 1'b1);
        tick(1);
        check_output("timeout_rx_rst_fall", P_RX_RST, 1'b0);
        check_output("timeout_rxdone", o_rxlane_done, 1'b0);
`else
        tick(12000);
        check_output("noalign_rx_rst_stay", P_RX_RST, 1'b0);
        check_output("noalign_rxdone_stay", o_rxlane_done, 1'b0);
        check_output("noalign_txdone_stay", o_txlane_done, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
